// File: rtl/alu_pkg.sv
// Shared ALU control codes, R-type funct encodings and multiply/divide sequencer states.
// The divide encodings are only decoded when ALU_DIV_EN is defined.
package alu_pkg;

    typedef logic [3:0] ctrl_code_t;

    localparam ctrl_code_t CTRL_AND  = 4'd0;
    localparam ctrl_code_t CTRL_OR   = 4'd1;
    localparam ctrl_code_t CTRL_ADD  = 4'd2;
    localparam ctrl_code_t CTRL_NOP  = 4'd3;
    localparam ctrl_code_t CTRL_NOR  = 4'd4;
    localparam ctrl_code_t CTRL_XOR  = 4'd5;
    localparam ctrl_code_t CTRL_SUB  = 4'd6;
    localparam ctrl_code_t CTRL_SLT  = 4'd7;
    localparam ctrl_code_t CTRL_SLTU = 4'd8;
    localparam ctrl_code_t CTRL_SLL  = 4'd9;
    localparam ctrl_code_t CTRL_SRL  = 4'd10;
    localparam ctrl_code_t CTRL_SRA  = 4'd11;
    localparam ctrl_code_t CTRL_MFHI = 4'd12;
    localparam ctrl_code_t CTRL_MFLO = 4'd13;
    localparam ctrl_code_t CTRL_MDU  = 4'd14;

    localparam logic [1:0] OP_ADD   = 2'b00;
    localparam logic [1:0] OP_SUB   = 2'b01;
    localparam logic [1:0] OP_FUNCT = 2'b10;
    localparam logic [1:0] OP_NOP   = 2'b11;

    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_SRL   = 6'b000010;
    localparam logic [5:0] FN_SRA   = 6'b000011;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_XOR   = 6'b100110;
    localparam logic [5:0] FN_NOR   = 6'b100111;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_SLTU  = 6'b101011;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/alu_muldiv_seq.sv
// Iterative one-bit-per-cycle multiply/divide sequencer writing the HI/LO registers.
// The restoring divider is only built when ALU_DIV_EN is defined.
module alu_muldiv_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op_unsigned,
    input  logic             op_div,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [1:0]         state;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   acc_lo;
    logic [WIDTH-1:0]   mag_b;
    logic               neg_res;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic is_signed);
        return (is_signed && v[WIDTH-1]) ? -v : v;
    endfunction

    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);

    assign mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_b} : '0);
    assign prod     = {acc_hi, acc_lo};
    assign prod_fix = neg_res ? -prod : prod;

`ifdef ALU_DIV_EN
    logic               is_div;
    logic               div_zero;
    logic               neg_rem;
    logic [WIDTH-1:0]   raw_a;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH-1:0]   div_diff;
    logic               div_ge;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    // Remainder is kept below the divisor, so the trial difference always fits WIDTH bits.
    assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
    assign div_ge    = (div_shift >= {1'b0, mag_b});
    assign div_diff  = div_shift[WIDTH-1:0] - mag_b;
    assign quo_fix   = neg_res ? -acc_lo : acc_lo;
    assign rem_fix   = neg_rem ? -acc_hi : acc_hi;
`else
    logic unused_div;
    assign unused_div = op_div;
`endif

    always_ff @(posedge clk) begin
        if (state == ST_IDLE && start) begin
            acc_hi  <= '0;
            acc_lo  <= magnitude(opa, ~op_unsigned);
            mag_b   <= magnitude(opb, ~op_unsigned);
            neg_res <= ~op_unsigned & (opa[WIDTH-1] ^ opb[WIDTH-1]);
`ifdef ALU_DIV_EN
            is_div   <= op_div;
            div_zero <= (opb == '0);
            neg_rem  <= ~op_unsigned & opa[WIDTH-1];
            raw_a    <= opa;
`endif
        end else if (state == ST_RUN && cnt != CNT_W'(WIDTH)) begin
`ifdef ALU_DIV_EN
            if (is_div) begin
                acc_hi <= div_ge ? div_diff : div_shift[WIDTH-1:0];
                acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
            end else
`endif
            begin
                acc_hi <= mul_sum[WIDTH:1];
                acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
            end
        end
    end

    // The extra RUN cycle after the last iteration applies sign correction on the DONE write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_RUN;
                        cnt   <= '0;
                    end
                end
                ST_RUN: begin
                    if (cnt == CNT_W'(WIDTH)) begin
                        state <= ST_DONE;
`ifdef ALU_DIV_EN
                        if (is_div) begin
                            if (div_zero) begin
                                hi <= raw_a;
                                lo <= '1;
                            end else begin
                                hi <= rem_fix;
                                lo <= quo_fix;
                            end
                        end else
`endif
                        begin
                            hi <= prod_fix[2*WIDTH-1:WIDTH];
                            lo <= prod_fix[WIDTH-1:0];
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/alu_ctrl_unit.sv
// ALU control decoder with an iterative multiply/divide unit and HI/LO registers.
// Define ALU_DIV_EN to decode DIV/DIVU and build the divider.
module alu_ctrl_unit
    import alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [1:0]        i_aluop,
    input  logic [5:0]        i_funct,
    input  logic              i_start,
    input  logic [WIDTH-1:0]  i_opa,
    input  logic [WIDTH-1:0]  i_opb,
    output logic [CTRL_W-1:0] o_aluctrl,
    output logic              o_busy,
    output logic              o_done,
    output logic [WIDTH-1:0]  o_hi,
    output logic [WIDTH-1:0]  o_lo
);

    ctrl_code_t funct_code;
    ctrl_code_t code;
    logic       launch;

    always_comb begin
        funct_code = CTRL_NOP;
        case (i_funct)
            FN_ADD, FN_ADDU:   funct_code = CTRL_ADD;
            FN_SUB, FN_SUBU:   funct_code = CTRL_SUB;
            FN_AND:            funct_code = CTRL_AND;
            FN_OR:             funct_code = CTRL_OR;
            FN_XOR:            funct_code = CTRL_XOR;
            FN_NOR:            funct_code = CTRL_NOR;
            FN_SLT:            funct_code = CTRL_SLT;
            FN_SLTU:           funct_code = CTRL_SLTU;
            FN_SLL:            funct_code = CTRL_SLL;
            FN_SRL:            funct_code = CTRL_SRL;
            FN_SRA:            funct_code = CTRL_SRA;
            FN_MFHI:           funct_code = CTRL_MFHI;
            FN_MFLO:           funct_code = CTRL_MFLO;
            FN_MULT, FN_MULTU: funct_code = CTRL_MDU;
`ifdef ALU_DIV_EN
            FN_DIV, FN_DIVU:   funct_code = CTRL_MDU;
`endif
            default:           funct_code = CTRL_NOP;
        endcase
    end

    always_comb begin
        code = CTRL_NOP;
        case (i_aluop)
            OP_ADD:   code = CTRL_ADD;
            OP_SUB:   code = CTRL_SUB;
            OP_FUNCT: code = funct_code;
            default:  code = CTRL_NOP;
        endcase
    end

    assign o_aluctrl = CTRL_W'(code);
    assign launch    = i_start && (i_aluop == OP_FUNCT) && (code == CTRL_MDU);

    alu_muldiv_seq #(
        .WIDTH(WIDTH)
    ) u_seq (
        .clk         (i_clk),
        .rst         (i_rst),
        .start       (launch),
        .op_unsigned (i_funct[0]),
        .op_div      (i_funct[1]),
        .opa         (i_opa),
        .opb         (i_opb),
        .busy        (o_busy),
        .done        (o_done),
        .hi          (o_hi),
        .lo          (o_lo)
    );

endmodule

// File: tb/tb_alu_ctrl_unit.sv
// Randomized self-checking bench for alu_ctrl_unit against an arithmetic reference model.
// Divide scenarios are exercised only when ALU_DIV_EN is defined.
module tb_alu_ctrl_unit;

    localparam int W = 32;

    logic         i_clk = 1'b0;
    logic         i_rst;
    logic [1:0]   i_aluop;
    logic [5:0]   i_funct;
    logic         i_start;
    logic [W-1:0] i_opa;
    logic [W-1:0] i_opb;
    logic [3:0]   o_aluctrl;
    logic         o_busy;
    logic         o_done;
    logic [W-1:0] o_hi;
    logic [W-1:0] o_lo;

    int n_checks = 0;
    int n_errors = 0;
    int code_tbl[64];
    logic [63:0] prev_hilo = '0;

    alu_ctrl_unit #(.WIDTH(W), .CTRL_W(4)) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_aluop   (i_aluop),
        .i_funct   (i_funct),
        .i_start   (i_start),
        .i_opa     (i_opa),
        .i_opb     (i_opb),
        .o_aluctrl (o_aluctrl),
        .o_busy    (o_busy),
        .o_done    (o_done),
        .o_hi      (o_hi),
        .o_lo      (o_lo)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // {hi, lo} the specification requires for one multiply/divide
    function automatic logic [63:0] model(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
        longint q, r;
        logic [63:0] ua, ub;
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (fn)
            6'b011000: return 64'(longint'($signed(a)) * longint'($signed(b)));
            6'b011001: return ua * ub;
            6'b011010: begin
                if (b == 0) return {a, 32'hFFFFFFFF};
                q = longint'($signed(a)) / longint'($signed(b));
                r = longint'($signed(a)) % longint'($signed(b));
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 0) return {a, 32'hFFFFFFFF};
                return {32'(ua % ub), 32'(ua / ub)};
            end
        endcase
    endfunction

    task automatic run_op(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b, input bit disturb);
        logic [63:0] exp;
        exp = model(fn, a, b);
        @(negedge i_clk);
        i_aluop = 2'b10; i_funct = fn; i_opa = a; i_opb = b; i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        check("busy_at_launch", 64'(o_busy), 64'd1);
        check("done_at_launch", 64'(o_done), 64'd0);
        for (int k = 1; k <= W + 2; k++) begin
            if (disturb && k == 4) begin
                i_start = 1'b1; i_opa = $urandom; i_opb = $urandom;
            end
            if (disturb && k == 9) i_start = 1'b0;
            @(posedge i_clk); #1;
            check("done_timing", 64'(o_done), 64'(k == W + 1));
            check("busy_timing", 64'(o_busy), 64'(k <= W));
            if (k <= W) check("hilo_hold", {o_hi, o_lo}, prev_hilo);
            else check("hilo_result", {o_hi, o_lo}, exp);
        end
        prev_hilo = exp;
    endtask

    initial begin
        int seen;
        logic [5:0] fn;
        logic [31:0] a, b;

        for (int i = 0; i < 64; i++) code_tbl[i] = 3;
        code_tbl[6'b100000] = 2;  code_tbl[6'b100001] = 2;
        code_tbl[6'b100010] = 6;  code_tbl[6'b100011] = 6;
        code_tbl[6'b100100] = 0;  code_tbl[6'b100101] = 1;
        code_tbl[6'b100110] = 5;  code_tbl[6'b100111] = 4;
        code_tbl[6'b101010] = 7;  code_tbl[6'b101011] = 8;
        code_tbl[6'b000000] = 9;  code_tbl[6'b000010] = 10;
        code_tbl[6'b000011] = 11; code_tbl[6'b010000] = 12;
        code_tbl[6'b010010] = 13; code_tbl[6'b011000] = 14;
        code_tbl[6'b011001] = 14;
`ifdef ALU_DIV_EN
        code_tbl[6'b011010] = 14; code_tbl[6'b011011] = 14;
`endif

        i_rst = 1'b1; i_aluop = 2'b00; i_funct = '0; i_start = 1'b0; i_opa = '0; i_opb = '0;
        #1;
        check("rst_busy", 64'(o_busy), 64'd0);
        check("rst_done", 64'(o_done), 64'd0);
        check("rst_hilo", {o_hi, o_lo}, 64'd0);
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;

        // Decoder: every funct under aluop=10, then the fixed classes
        for (int f = 0; f < 64; f++) begin
            i_aluop = 2'b10; i_funct = 6'(f);
            #1;
            check($sformatf("dec_funct_%02h", f), 64'(o_aluctrl), 64'(code_tbl[f]));
        end
        for (int i = 0; i < 12; i++) begin
            i_aluop = 2'(i % 4); i_funct = 6'($urandom);
            #1;
            check("dec_aluop", 64'(o_aluctrl),
                  64'((i % 4 == 0) ? 2 : (i % 4 == 1) ? 6 : (i % 4 == 3) ? 3 : code_tbl[i_funct]));
        end

        run_op(6'b011000, 32'd7, 32'hFFFFFFFD, 1'b0);
        check("mult_vector", {o_hi, o_lo}, 64'hFFFFFFFF_FFFFFFEB);
        run_op(6'b011001, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        check("multu_vector", {o_hi, o_lo}, 64'hFFFFFFFE_00000001);
        run_op(6'b011000, 32'h12345678, 32'h9ABCDEF0, 1'b1);

`ifdef ALU_DIV_EN
        run_op(6'b011011, 32'd100, 32'd7, 1'b0);
        check("divu_vector", {o_hi, o_lo}, 64'h00000002_0000000E);
        run_op(6'b011010, 32'hFFFFFFF9, 32'd2, 1'b0);
        check("div_vector", {o_hi, o_lo}, 64'hFFFFFFFF_FFFFFFFD);
        run_op(6'b011011, 32'd5, 32'd0, 1'b0);
        check("divu_zero", {o_hi, o_lo}, 64'h00000005_FFFFFFFF);
        run_op(6'b011010, 32'hFFFFFF9C, 32'd0, 1'b0);
        run_op(6'b011010, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        run_op(6'b011010, 32'h8000_1234, 32'd17, 1'b1);
`else
        // Divide encodings are not multiply/divide ops in this build
        @(negedge i_clk);
        i_aluop = 2'b10; i_funct = 6'b011010; i_opa = 32'd9; i_opb = 32'd3; i_start = 1'b1;
        #1;
        check("nodiv_decode", 64'(o_aluctrl), 64'd3);
        for (int k = 0; k < 3; k++) begin
            @(posedge i_clk); #1;
            check("nodiv_busy", 64'(o_busy), 64'd0);
            check("nodiv_hilo", {o_hi, o_lo}, prev_hilo);
        end
        i_start = 1'b0;
`endif

        // Reset in the middle of an iteration
        @(negedge i_clk);
        i_aluop = 2'b10; i_funct = 6'b011001; i_opa = 32'hDEADBEEF; i_opb = 32'h1234; i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        repeat (10) @(posedge i_clk);
        #1 i_rst = 1'b1;
        #1;
        check("midrst_busy", 64'(o_busy), 64'd0);
        check("midrst_done", 64'(o_done), 64'd0);
        check("midrst_hilo", {o_hi, o_lo}, 64'd0);
        @(negedge i_clk);
        i_rst = 1'b0;
        seen = 0;
        for (int k = 0; k < W + 6; k++) begin
            @(posedge i_clk); #1;
            if (o_done || o_busy) seen++;
        end
        check("midrst_no_done", 64'(seen), 64'd0);
        prev_hilo = '0;
        run_op(6'b011000, 32'hFFFF0000, 32'h00010001, 1'b0);

        for (int i = 0; i < 24; i++) begin
`ifdef ALU_DIV_EN
            fn = {4'b0110, 2'($urandom_range(0, 3))};
`else
            fn = {5'b01100, 1'($urandom_range(0, 1))};
`endif
            a = $urandom;
            b = (i % 3 == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            if (i % 5 == 0) a = -a;
            run_op(fn, a, b, (i % 4) == 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
